if_id_reg: RTL and testbench
============================

Name: if_id_reg

Overview:
- IF/ID pipeline boundary register of the MIPS core. Sits directly downstream of the instruction-fetch select stage and consumes its next-instruction address and current instruction.
- Decouples fetch from decode with a valid/ready handshake and a 2-entry skid buffer, so decode stalls never drop a fetched instruction.
- Supports a synchronous flush for branch/jump redirects; a flushed slot is presented to decode as a NOP bubble.

Parameters:
- PC_W, 32, width of the PC+4 value carried with each instruction.
- INS_W, 32, instruction word width.
- NOP_INS, 32'h0000_0000, instruction driven on ID_INS when the slot is not valid (sll $0,$0,0).
- CNT_W, 16, width of the perf counters; only used when IFID_PERF_CNT_EN is defined.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST_N  in  1  asynchronous active-low reset.
- IF_VALID  in  1  fetch stage presents a valid instruction.
- IF_READY  out  1  register can accept a word this cycle.
- IF_PC_NEXT  in  PC_W  PC+4 / next instruction address from fetch select.
- IF_INS  in  INS_W  current instruction from fetch.
- FLUSH  in  1  discard all held and incoming instructions.
- ID_VALID  out  1  decode slot holds a valid instruction.
- ID_READY  in  1  decode accepts the slot this cycle; low means stall.
- ID_PC_NEXT  out  PC_W  PC+4 of the slot instruction.
- ID_INS  out  INS_W  slot instruction.

Behaviour:
- Storage is a main entry M {valid, pc, ins}, which drives the ID_* outputs, and a skid entry S {valid, pc, ins}. Occupancy is 0, 1 or 2.
- Reset (RST_N low, asynchronous): M.valid=0, S.valid=0, all data fields 0.
  - Outputs during reset: IF_READY=1, ID_VALID=0, ID_INS=NOP_INS, ID_PC_NEXT=0.
  - Release is synchronous to the next rising edge.
- Handshakes:
  - Input transfer: IF_VALID && IF_READY.
  - Output transfer: ID_VALID && ID_READY.
- IF_READY = !S.valid. It is a registered term, with no combinational path from ID_READY.
- ID_VALID = M.valid.
- When ID_VALID=0, ID_INS=NOP_INS and ID_PC_NEXT=0 (combinational gating).
- Latency: a word accepted at edge N appears on ID_* after edge N, i.e. 1 cycle, when the register is empty.
- Next-state at each edge, FLUSH=0:
  - Occ 0, input transfer: word goes to M.
  - Occ 1, input and output transfer: word goes to M (replaces the consumed entry).
  - Occ 1, input only: word goes to S (decode stalled), and IF_READY falls next cycle.
  - Occ 1, output only: M.valid=0.
  - Occ 2 (no input possible), output transfer: S moves to M, S.valid=0, and IF_READY rises next cycle.
  - Occ 2, no output: hold everything.
- FLUSH=1 at an edge has priority over every other event:
  - M.valid=0 and S.valid=0.
  - An input transfer in the same cycle is accepted (handshake completes) but discarded.
  - An output transfer in the same cycle still counts as consumed by decode.
  - The next cycle has ID_VALID=0 and IF_READY=1.
- Data held in M/S must not change while its entry is valid and not transferred (stable under stall).
- Order is strict FIFO: M is always older than S.
- Asserting reset mid-stall clears both entries immediately; no word survives reset.

Optional Feature:
- Macro: IFID_PERF_CNT_EN.
- Defined: adds outputs STALL_CNT (CNT_W) and FLUSH_CNT (CNT_W), both reset to 0 asynchronously.
  - STALL_CNT increments on each edge where ID_VALID && !ID_READY.
  - FLUSH_CNT increments on each edge where FLUSH=1.
  - Both saturate at all-ones and never wrap.
- Not defined: ports and counter logic are absent; the remaining behaviour is identical.

Test Plan:
1. Reset/idle: hold RST_N=0 with IF_VALID=1 and IF_INS=32'h2008_0005. Required: ID_VALID=0, ID_INS=0, IF_READY=1. Release, then present IF_PC_NEXT=4, IF_INS=32'h2008_0005 with ID_READY=1. Required one edge later: ID_VALID=1, ID_PC_NEXT=4, ID_INS=32'h2008_0005.
2. Streaming: ID_READY=1 with words at PC_NEXT 4,8,12,16 on consecutive cycles. Required: outputs follow at 1-cycle latency with no bubbles, and IF_READY stays 1.
3. Stall/skid: M holds PC_NEXT=8; drop ID_READY; present PC_NEXT=12. Required: S captures 12, then IF_READY=0 with ID_PC_NEXT stable at 8. Raise ID_READY. Required: 12 then the next word (16) appear on consecutive cycles with no loss or duplication.
4. Flush while full: occupancy 2 (8, 12), assert FLUSH for 1 cycle with IF_VALID=1 and PC_NEXT=16. Required next cycle: ID_VALID=0, ID_INS=NOP_INS, IF_READY=1. Word 16 is never delivered.
5. Async reset mid-stall: occupancy 2, pull RST_N low between edges. Required: ID_VALID=0 and IF_READY=1 immediately, without waiting for CLK.
6. IFID_PERF_CNT_EN defined: 5 stalled cycles plus 2 FLUSH pulses. Required: STALL_CNT=5, FLUSH_CNT=2. With CNT_W=4 and 20 stall cycles, STALL_CNT=15 (saturated).

Source files
------------

// File: rtl/if_id_reg.sv
// ============================================================================
// if_id_reg
// ----------------------------------------------------------------------------
// IF/ID pipeline boundary register of the MIPS core. It sits between the
// instruction-fetch select stage and decode. A valid/ready handshake on both
// sides, backed by a 2-entry skid buffer, means a decode stall never loses a
// fetched instruction. A synchronous FLUSH for branch/jump redirects empties
// both entries. An empty slot is shown to decode as a NOP bubble.
//
// Storage
//   M (main) : drives the ID_* outputs and always holds the oldest word.
//   S (skid) : catches the word that arrives while decode is stalled.
//   Occupancy is 0 (none valid), 1 (M valid) or 2 (M and S valid).
//
// Parameters
//   PC_W    : width of the PC+4 value carried with each instruction
//   INS_W   : instruction word width
//   NOP_INS : instruction driven on ID_INS while the slot is empty
//   CNT_W   : perf counter width (present only with IFID_PERF_CNT_EN)
//
// Ports
//   CLK        in   clock, rising edge active
//   RST_N      in   asynchronous active-low reset
//   IF_VALID   in   fetch presents a valid instruction
//   IF_READY   out  register can accept a word (registered, equals !S.valid)
//   IF_PC_NEXT in   PC+4 of the fetched instruction
//   IF_INS     in   fetched instruction
//   FLUSH      in   discard every held and incoming instruction
//   ID_VALID   out  decode slot holds a valid instruction
//   ID_READY   in   decode consumes the slot this cycle (low = stall)
//   ID_PC_NEXT out  PC+4 of the slot instruction (0 when empty)
//   ID_INS     out  slot instruction (NOP_INS when empty)
//   STALL_CNT  out  saturating count of edges with ID_VALID && !ID_READY
//   FLUSH_CNT  out  saturating count of edges with FLUSH high
//
// Optional feature macro: IFID_PERF_CNT_EN
//   Defined     : CNT_W parameter and STALL_CNT / FLUSH_CNT ports and logic.
//   Not defined : those ports, the parameter and the counters are absent.
// ============================================================================
module if_id_reg #(
    parameter int unsigned          PC_W    = 32,
    parameter int unsigned          INS_W   = 32,
`ifdef IFID_PERF_CNT_EN
    parameter logic [INS_W-1:0]     NOP_INS = '0,
    parameter int unsigned          CNT_W   = 16
`else
    parameter logic [INS_W-1:0]     NOP_INS = '0
`endif
) (
    input  logic                CLK,
    input  logic                RST_N,

    input  logic                IF_VALID,
    output logic                IF_READY,
    input  logic [PC_W-1:0]     IF_PC_NEXT,
    input  logic [INS_W-1:0]    IF_INS,

    input  logic                FLUSH,

    output logic                ID_VALID,
    input  logic                ID_READY,
    output logic [PC_W-1:0]     ID_PC_NEXT,
`ifdef IFID_PERF_CNT_EN
    output logic [INS_W-1:0]    ID_INS,
    output logic [CNT_W-1:0]    STALL_CNT,
    output logic [CNT_W-1:0]    FLUSH_CNT
`else
    output logic [INS_W-1:0]    ID_INS
`endif
);

    // ------------------------------------------------------------------------
    // Storage: main entry M and skid entry S
    // ------------------------------------------------------------------------
    logic               mValid_q, mValid_d;
    logic [PC_W-1:0]    mPc_q,    mPc_d;
    logic [INS_W-1:0]   mIns_q,   mIns_d;

    logic               sValid_q, sValid_d;
    logic [PC_W-1:0]    sPc_q,    sPc_d;
    logic [INS_W-1:0]   sIns_q,   sIns_d;

    logic               inXfer;
    logic               outXfer;

    // IF_READY depends only on the skid flag, so decode's ready never reaches
    // back to fetch combinationally. S is the last free slot, so while it is
    // empty one more word can always be absorbed.
    assign IF_READY = ~sValid_q;
    assign ID_VALID = mValid_q;

    assign inXfer   = IF_VALID & IF_READY;
    assign outXfer  = mValid_q & ID_READY;

    // An empty slot is presented as a clean bubble so decode never acts on
    // stale data left behind in M.
    assign ID_INS     = mValid_q ? mIns_q : NOP_INS;
    assign ID_PC_NEXT = mValid_q ? mPc_q  : '0;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    // Data fields only load when their entry is (re)filled, so a stalled
    // entry keeps its contents bit-for-bit. FLUSH wins over everything. A
    // word handed over in the flush cycle completes its handshake but is
    // dropped, and a word decode takes in that cycle still counts as
    // consumed. Occupancy 2 has IF_READY low, so no input arrives then.
    always_comb begin
        mValid_d = mValid_q;
        mPc_d    = mPc_q;
        mIns_d   = mIns_q;
        sValid_d = sValid_q;
        sPc_d    = sPc_q;
        sIns_d   = sIns_q;

        if (FLUSH) begin
            mValid_d = 1'b0;
            sValid_d = 1'b0;
        end else if (sValid_q) begin
            // Full: only draining is possible; the skid word becomes main.
            if (outXfer) begin
                mValid_d = 1'b1;
                mPc_d    = sPc_q;
                mIns_d   = sIns_q;
                sValid_d = 1'b0;
            end
        end else if (mValid_q) begin
            if (inXfer && outXfer) begin
                mPc_d    = IF_PC_NEXT;
                mIns_d   = IF_INS;
            end else if (inXfer) begin
                sValid_d = 1'b1;
                sPc_d    = IF_PC_NEXT;
                sIns_d   = IF_INS;
            end else if (outXfer) begin
                mValid_d = 1'b0;
            end
        end else begin
            if (inXfer) begin
                mValid_d = 1'b1;
                mPc_d    = IF_PC_NEXT;
                mIns_d   = IF_INS;
            end
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    // Reset clears every field at once so that no word survives a reset, even
    // one caught mid-stall.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mValid_q <= 1'b0;
            mPc_q    <= '0;
            mIns_q   <= '0;
            sValid_q <= 1'b0;
            sPc_q    <= '0;
            sIns_q   <= '0;
        end else begin
            mValid_q <= mValid_d;
            mPc_q    <= mPc_d;
            mIns_q   <= mIns_d;
            sValid_q <= sValid_d;
            sPc_q    <= sPc_d;
            sIns_q   <= sIns_d;
        end
    end

`ifdef IFID_PERF_CNT_EN
    // ------------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------------
    // Both counters stop at all-ones, so a long run reads as "at least max"
    // rather than wrapping back to a misleading small value.
    logic [CNT_W-1:0] stallCnt_q, stallCnt_d;
    logic [CNT_W-1:0] flushCnt_q, flushCnt_d;

    always_comb begin
        stallCnt_d = stallCnt_q;
        flushCnt_d = flushCnt_q;
        if (mValid_q && !ID_READY && (stallCnt_q != {CNT_W{1'b1}})) begin
            stallCnt_d = stallCnt_q + 1'b1;
        end
        if (FLUSH && (flushCnt_q != {CNT_W{1'b1}})) begin
            flushCnt_d = flushCnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            stallCnt_q <= '0;
            flushCnt_q <= '0;
        end else begin
            stallCnt_q <= stallCnt_d;
            flushCnt_q <= flushCnt_d;
        end
    end

    assign STALL_CNT = stallCnt_q;
    assign FLUSH_CNT = flushCnt_q;
`endif

endmodule

// File: tb/tb_if_id_reg.sv
module tb_if_id_reg;

    localparam logic [31:0] NopIns = 32'h0000_0000;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        IF_VALID = 1'b0;
    logic [31:0] IF_PC_NEXT = '0;
    logic [31:0] IF_INS = '0;
    logic        FLUSH = 1'b0;
    logic        ID_READY = 1'b0;

    logic        IF_READY;
    logic        ID_VALID;
    logic [31:0] ID_PC_NEXT;
    logic [31:0] ID_INS;

    // Expected state from the queue model.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } word_t;

    word_t fifo[$];
    int    checks = 0;
    int    errors = 0;
    int    stallCnt = 0;
    int    flushCnt = 0;
    int    stallCnt4 = 0;

`ifdef IFID_PERF_CNT_EN
    logic [15:0] STALL_CNT;
    logic [15:0] FLUSH_CNT;
    logic [3:0]  STALL_CNT4;
    logic [3:0]  FLUSH_CNT4;
    logic        ifReady4;
    logic        idValid4;
    logic [31:0] idPc4;
    logic [31:0] idIns4;

    if_id_reg #(.PC_W(32), .INS_W(32), .NOP_INS(NopIns), .CNT_W(16)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .IF_VALID(IF_VALID), .IF_READY(IF_READY),
        .IF_PC_NEXT(IF_PC_NEXT), .IF_INS(IF_INS),
        .FLUSH(FLUSH),
        .ID_VALID(ID_VALID), .ID_READY(ID_READY),
        .ID_PC_NEXT(ID_PC_NEXT), .ID_INS(ID_INS),
        .STALL_CNT(STALL_CNT), .FLUSH_CNT(FLUSH_CNT)
    );

    if_id_reg #(.PC_W(32), .INS_W(32), .NOP_INS(NopIns), .CNT_W(4)) dut4 (
        .CLK(CLK), .RST_N(RST_N),
        .IF_VALID(IF_VALID), .IF_READY(ifReady4),
        .IF_PC_NEXT(IF_PC_NEXT), .IF_INS(IF_INS),
        .FLUSH(FLUSH),
        .ID_VALID(idValid4), .ID_READY(ID_READY),
        .ID_PC_NEXT(idPc4), .ID_INS(idIns4),
        .STALL_CNT(STALL_CNT4), .FLUSH_CNT(FLUSH_CNT4)
    );
`else
    if_id_reg #(.PC_W(32), .INS_W(32), .NOP_INS(NopIns)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .IF_VALID(IF_VALID), .IF_READY(IF_READY),
        .IF_PC_NEXT(IF_PC_NEXT), .IF_INS(IF_INS),
        .FLUSH(FLUSH),
        .ID_VALID(ID_VALID), .ID_READY(ID_READY),
        .ID_PC_NEXT(ID_PC_NEXT), .ID_INS(ID_INS)
    );
`endif

    // Free-running clock, 10 time units per cycle.
    always #5 CLK = ~CLK;

    // Single comparison point: counts the check and reports any difference.
    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare the visible DUT outputs against the queue model.
    task automatic checkOutput(input string tag);
        logic        expValid;
        logic [31:0] expIns;
        logic [31:0] expPc;
        expValid = (fifo.size() > 0);
        expIns   = expValid ? fifo[0].ins : NopIns;
        expPc    = expValid ? fifo[0].pc  : 32'h0;
        checkEq({tag, ".ID_VALID"},   {31'b0, ID_VALID}, {31'b0, expValid});
        checkEq({tag, ".ID_INS"},     ID_INS, expIns);
        checkEq({tag, ".ID_PC_NEXT"}, ID_PC_NEXT, expPc);
        checkEq({tag, ".IF_READY"},   {31'b0, IF_READY}, {31'b0, fifo.size() < 2});
`ifdef IFID_PERF_CNT_EN
        checkEq({tag, ".STALL_CNT"},  {16'b0, STALL_CNT}, stallCnt);
        checkEq({tag, ".FLUSH_CNT"},  {16'b0, FLUSH_CNT}, flushCnt);
        checkEq({tag, ".STALL_CNT4"}, {28'b0, STALL_CNT4}, stallCnt4);
`endif
    endtask

    // Reference model: a FIFO of at most two words with priority flush.
    task automatic modelReset();
        fifo.delete();
        stallCnt  = 0;
        flushCnt  = 0;
        stallCnt4 = 0;
    endtask

    task automatic modelEdge();
        bit    inX;
        bit    outX;
        word_t w;
        if (!RST_N) begin
            modelReset();
        end else begin
            inX  = IF_VALID && (fifo.size() < 2);
            outX = (fifo.size() > 0) && ID_READY;
            if ((fifo.size() > 0) && !ID_READY) begin
                if (stallCnt < 65535) stallCnt++;
                if (stallCnt4 < 15) stallCnt4++;
            end
            if (FLUSH) begin
                if (flushCnt < 65535) flushCnt++;
                fifo.delete();
            end else begin
                if (outX) void'(fifo.pop_front());
                if (inX) begin
                    w.pc  = IF_PC_NEXT;
                    w.ins = IF_INS;
                    fifo.push_back(w);
                end
            end
        end
    endtask

    // Drive all inputs at once, away from the active edge.
    task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                                 input logic rdy, input logic fl);
        IF_VALID   = v;
        IF_PC_NEXT = pc;
        IF_INS     = ins;
        ID_READY   = rdy;
        FLUSH      = fl;
    endtask

    // One clock: the model advances with the edge, outputs checked 1 unit later.
    task automatic stepCycle(input string tag);
        @(posedge CLK);
        modelEdge();
        #1;
        checkOutput(tag);
    endtask

    initial begin
        $display("[TB] if_id_reg bench start");

        // Reset and idle.
        applyStimulus(1'b1, 32'd4, 32'h2008_0005, 1'b1, 1'b0);
        #2;
        modelReset();
        checkOutput("reset_hold");
        stepCycle("reset_edge");
        RST_N = 1'b1;
        stepCycle("first_word");
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        stepCycle("drain");

        // Streaming with decode always ready.
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, 32'(i * 4), 32'h1000_0000 + 32'(i), 1'b1, 1'b0);
            stepCycle("stream");
        end
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        stepCycle("stream_end");

        // Stall into the skid entry, then release.
        applyStimulus(1'b1, 32'd8, 32'hA000_0008, 1'b1, 1'b0);
        stepCycle("skid_m8");
        applyStimulus(1'b1, 32'd12, 32'hA000_000C, 1'b0, 1'b0);
        stepCycle("skid_s12");
        applyStimulus(1'b1, 32'd16, 32'hA000_0010, 1'b0, 1'b0);
        stepCycle("skid_full");
        applyStimulus(1'b1, 32'd16, 32'hA000_0010, 1'b1, 1'b0);
        stepCycle("skid_drain12");
        stepCycle("skid_take16");
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        stepCycle("skid_empty");

        // Flush while full; the word offered in the flush cycle is dropped.
        applyStimulus(1'b1, 32'd8, 32'hB000_0008, 1'b1, 1'b0);
        stepCycle("fl_m8");
        applyStimulus(1'b1, 32'd12, 32'hB000_000C, 1'b0, 1'b0);
        stepCycle("fl_s12");
        applyStimulus(1'b1, 32'd16, 32'hB000_0010, 1'b0, 1'b1);
        stepCycle("fl_pulse");
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        stepCycle("fl_after");

        // Async reset in the middle of a full stall.
        applyStimulus(1'b1, 32'd8, 32'hC000_0008, 1'b0, 1'b0);
        stepCycle("ar_m8");
        applyStimulus(1'b1, 32'd12, 32'hC000_000C, 1'b0, 1'b0);
        stepCycle("ar_s12");
        #1;
        RST_N = 1'b0;
        #1;
        modelReset();
        checkOutput("ar_immediate");
        stepCycle("ar_held");
        RST_N = 1'b1;
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        stepCycle("ar_release");

        // 5 stalled cycles and 2 flush pulses, then a long stall for saturation.
        applyStimulus(1'b1, 32'd40, 32'hD000_0028, 1'b0, 1'b0);
        stepCycle("pc_load");
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) stepCycle("pc_stall");
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
        stepCycle("pc_flush1");
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        stepCycle("pc_gap");
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
        stepCycle("pc_flush2");
        applyStimulus(1'b1, 32'd44, 32'hD000_002C, 1'b0, 1'b0);
        stepCycle("pc_load2");
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) stepCycle("pc_sat");

        // Randomized traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
                          1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 15) == 0));
            stepCycle("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
